wave_rom_arbiter: RTL

Shares one synchronous waveform ROM among the three note players, each of which needs one sample lookup per sample tick. Round-robin arbiter: accepts level requests with addresses, issues at most one ROM read per cycle, tracks in-flight reads through the ROM latency, and returns each sample to its owner with a one-cycle acknowledge. Sits between the note players and the waveform ROM.

---
 rtl/wave_rom_arbiter_pkg.sv | 28 ++
 rtl/wave_rom_arbiter_rr_pick3.sv | 30 +++
 rtl/wave_rom_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/wave_rom_arbiter_pkg.sv
// Shared constants and types for the waveform ROM arbiter.
// Player indices, default widths and the tag carried alongside each ROM read.
package wave_rom_arbiter_pkg;

   localparam int DEF_ADDR_W      = 10;
   localparam int DEF_DATA_W      = 16;
   localparam int DEF_ROM_LATENCY = 1;
   localparam int N_PLAYERS       = 3;

   localparam logic [1:0] P1 = 2'd0;
   localparam logic [1:0] P2 = 2'd1;
   localparam logic [1:0] P3 = 2'd2;

   typedef struct packed {
      logic       valid;
      logic [1:0] idx;
   } tag_t;

   function automatic logic [N_PLAYERS-1:0] onehot3(input logic [1:0] idx);
      logic [N_PLAYERS-1:0] v;
      v = '0;
      if (idx == P1) v[0] = 1'b1;
      if (idx == P2) v[1] = 1'b1;
      if (idx == P3) v[2] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/wave_rom_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: search begins at the player after
// `last`, wrapping, and the first eligible player wins.
module rr_pick3
   import wave_rom_arbiter_pkg::*;
(
   input  logic [2:0] eligible,
   input  logic [1:0] last,
   output logic       grant_valid,
   output logic [1:0] grant_idx
);

   int start;
   int cand;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = P1;
      start       = (last >= P3) ? 0 : int'(last) + 1;
      cand        = 0;
      // Walk offsets from farthest to nearest so the nearest eligible wins.
      for (int i = N_PLAYERS - 1; i >= 0; i--) begin
         cand = (start + i) % N_PLAYERS;
         if (eligible[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = 2'(cand);
         end
      end
   end

endmodule

// File: rtl/wave_rom_arbiter.sv
// Round-robin sharing of one synchronous waveform ROM among three note players;
// each grant carries a tag through the ROM latency so the sample returns to its owner.
module wave_rom_arbiter
   import wave_rom_arbiter_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ROM_LATENCY = DEF_ROM_LATENCY
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              arb_enable,
   input  logic [2:0]        req,
   input  logic [ADDR_W-1:0] addr_1,
   input  logic [ADDR_W-1:0] addr_2,
   input  logic [ADDR_W-1:0] addr_3,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] sample,
   output logic [2:0]        ack,
   output logic              protocol_err
);

   logic [2:0]        busy_reg;
   logic [1:0]        last_reg;
   logic              rom_en_reg;
   logic [ADDR_W-1:0] rom_addr_reg;
   logic [DATA_W-1:0] sample_reg;
   logic [2:0]        ack_reg;
   logic              protocol_err_reg;

   logic [2:0]        eligible;
   logic              grant_valid;
   logic [1:0]        grant_idx;
   logic [ADDR_W-1:0] addr_sel;
   logic [2:0]        grant_vec;
   tag_t              tag_out;

   tag_t tag_line_reg [ROM_LATENCY+1];

   assign eligible  = arb_enable ? (req & ~busy_reg) : 3'b000;
   assign grant_vec = grant_valid ? onehot3(grant_idx) : 3'b000;
   assign tag_out   = tag_line_reg[ROM_LATENCY];

   rr_pick3 u_pick (
      .eligible    (eligible),
      .last        (last_reg),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   always_comb begin
      addr_sel = addr_1;
      case (grant_idx)
         P2:      addr_sel = addr_2;
         P3:      addr_sel = addr_3;
         default: addr_sel = addr_1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_line_reg[0] <= '0;
      end else begin
         tag_line_reg[0] <= '{valid: grant_valid, idx: grant_idx};
      end
   end

   for (genvar gi = 1; gi <= ROM_LATENCY; gi++) begin : g_tag_line
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) tag_line_reg[gi] <= '0;
         else          tag_line_reg[gi] <= tag_line_reg[gi-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_reg         <= '0;
         last_reg         <= P3;
         rom_en_reg       <= 1'b0;
         rom_addr_reg     <= '0;
         sample_reg       <= '0;
         ack_reg          <= '0;
         protocol_err_reg <= 1'b0;
      end else begin
         // busy stays set through the ack cycle, so the next grant is one cycle later.
         busy_reg   <= (busy_reg & ~ack_reg) | grant_vec;
         rom_en_reg <= grant_valid;
         if (grant_valid) begin
            last_reg     <= grant_idx;
            rom_addr_reg <= addr_sel;
         end
         if (tag_out.valid) begin
            sample_reg <= rom_data;
            ack_reg    <= onehot3(tag_out.idx);
         end else begin
            ack_reg    <= '0;
         end
         if (|(busy_reg & ~ack_reg & ~req)) protocol_err_reg <= 1'b1;
      end
   end

   assign rom_en       = rom_en_reg;
   assign rom_addr     = rom_addr_reg;
   assign sample       = sample_reg;
   assign ack          = ack_reg;
   assign protocol_err = protocol_err_reg;

endmodule
